// File: rtl/sseg_to_bin_monitor_if.sv
// Observed seven-segment bus plus the decoded frame produced by sseg_to_bin_monitor.
// master = display side / bench, slave = the monitor.
interface sseg_to_bin_monitor_if;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        clr;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  bad_digit;
  logic        valid;
  logic        frame_tick;
  logic        stale;

  modport master (
    output an, sseg, clr,
    input  value, dp, bad_digit, valid, frame_tick, stale
  );

  modport slave (
    input  an, sseg, clr,
    output value, dp, bad_digit, valid, frame_tick, stale
  );
endinterface

// File: rtl/sseg_to_bin_monitor.sv
// Reconstructs the 4-digit hex value shown on a multiplexed active-low seven-segment display.
// Digits are captured once stable, and a frame is published when all four have been seen.
module sseg_to_bin_monitor #(
  parameter int STABLE_CYC = 16,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sseg_to_bin_monitor_if.slave  bus
);
  typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_SETTLE = 2'd1, ST_HOLD = 2'd2} state_t;

  localparam logic [7:0]           CAP_CNT = 8'(STABLE_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] TMO_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  // Returns {bad, nibble}; unknown patterns decode to 0 with bad set.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'h40:   return {1'b0, 4'h0};
      7'h79:   return {1'b0, 4'h1};
      7'h24:   return {1'b0, 4'h2};
      7'h30:   return {1'b0, 4'h3};
      7'h19:   return {1'b0, 4'h4};
      7'h12:   return {1'b0, 4'h5};
      7'h02:   return {1'b0, 4'h6};
      7'h78:   return {1'b0, 4'h7};
      7'h00:   return {1'b0, 4'h8};
      7'h10:   return {1'b0, 4'h9};
      7'h08:   return {1'b0, 4'hA};
      7'h03:   return {1'b0, 4'hB};
      7'h46:   return {1'b0, 4'hC};
      7'h21:   return {1'b0, 4'hD};
      7'h06:   return {1'b0, 4'hE};
      7'h0E:   return {1'b0, 4'hF};
      default: return {1'b1, 4'h0};
    endcase
  endfunction

  function automatic logic [2:0] onehot_low_idx(input logic [3:0] an_v);
    case (an_v)
      4'b1110: return {1'b1, 2'd0};
      4'b1101: return {1'b1, 2'd1};
      4'b1011: return {1'b1, 2'd2};
      4'b0111: return {1'b1, 2'd3};
      default: return {1'b0, 2'd0};
    endcase
  endfunction

  logic [3:0]           an_meta_r, an_sync_r, an_prev_r;
  logic [7:0]           sseg_meta_r, sseg_sync_r, sseg_prev_r;
  state_t               state_r;
  logic [7:0]           cnt_r;
  logic [3:0]           mask_r;
  logic [15:0]          stg_value_r;
  logic [3:0]           stg_dp_r, stg_bad_r;
  logic [TIMEOUT_W-1:0] tmo_r;
  logic [15:0]          value_r;
  logic [3:0]           dp_r, bad_r;
  logic                 valid_r, frame_tick_r, stale_r;

  logic [2:0]           sel_s;
  logic                 sel_ok_s;
  logic [1:0]           sel_idx_s;
  logic                 same_s;
  logic [4:0]           glyph_s;
  logic                 capture_s;
  logic                 publish_s;
  logic [TIMEOUT_W-1:0] tmo_nxt_s;

  assign sel_s     = onehot_low_idx(an_sync_r);
  assign sel_ok_s  = sel_s[2];
  assign sel_idx_s = sel_s[1:0];
  assign same_s    = (an_sync_r == an_prev_r) && (sseg_sync_r == sseg_prev_r);
  assign glyph_s   = decode_glyph(sseg_sync_r[6:0]);
  assign capture_s = (state_r == ST_SETTLE) && sel_ok_s && same_s && (cnt_r == CAP_CNT);
  assign publish_s = (mask_r == 4'hF);
  assign tmo_nxt_s = publish_s ? {TIMEOUT_W{1'b0}} :
                     (tmo_r == TMO_MAX) ? TMO_MAX : (tmo_r + TMO_ONE);

  // Two-flop synchronizer plus one-cycle history for change detection; clr leaves it running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_meta_r   <= 4'h0;
      an_sync_r   <= 4'h0;
      an_prev_r   <= 4'h0;
      sseg_meta_r <= 8'h00;
      sseg_sync_r <= 8'h00;
      sseg_prev_r <= 8'h00;
    end else begin
      an_meta_r   <= bus.an;
      an_sync_r   <= an_meta_r;
      an_prev_r   <= an_sync_r;
      sseg_meta_r <= bus.sseg;
      sseg_sync_r <= sseg_meta_r;
      sseg_prev_r <= sseg_sync_r;
    end
  end

  // Digit FSM: WAIT for a single enable, SETTLE until stable, HOLD after capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_WAIT;
      cnt_r       <= 8'd0;
      mask_r      <= 4'h0;
      stg_value_r <= 16'h0000;
      stg_dp_r    <= 4'h0;
      stg_bad_r   <= 4'h0;
    end else if (bus.clr) begin
      state_r     <= ST_WAIT;
      cnt_r       <= 8'd0;
      mask_r      <= 4'h0;
      stg_value_r <= 16'h0000;
      stg_dp_r    <= 4'h0;
      stg_bad_r   <= 4'h0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          cnt_r   <= 8'd0;
          state_r <= sel_ok_s ? ST_SETTLE : ST_WAIT;
        end
        ST_SETTLE: begin
          if (!sel_ok_s) begin
            state_r <= ST_WAIT;
            cnt_r   <= 8'd0;
          end else if (!same_s) begin
            cnt_r   <= 8'd0;
          end else if (cnt_r == CAP_CNT) begin
            state_r <= ST_HOLD;
            cnt_r   <= 8'd0;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
          end
        end
        ST_HOLD: begin
          cnt_r <= 8'd0;
          if (!same_s) begin
            state_r <= sel_ok_s ? ST_SETTLE : ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_WAIT;
          cnt_r   <= 8'd0;
        end
      endcase
      // A capture coinciding with publish lands in the freshly cleared mask.
      mask_r <= (publish_s ? 4'h0 : mask_r) | (capture_s ? (4'b0001 << sel_idx_s) : 4'h0);
      if (capture_s) begin
        stg_value_r[{sel_idx_s, 2'b00} +: 4] <= glyph_s[3:0];
        stg_dp_r[sel_idx_s]                  <= ~sseg_sync_r[7];
        stg_bad_r[sel_idx_s]                 <= glyph_s[4];
      end
    end
  end

  // Frame publish and timeout supervision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_r        <= {TIMEOUT_W{1'b0}};
      value_r      <= 16'h0000;
      dp_r         <= 4'h0;
      bad_r        <= 4'h0;
      valid_r      <= 1'b0;
      frame_tick_r <= 1'b0;
      stale_r      <= 1'b0;
    end else if (bus.clr) begin
      tmo_r        <= {TIMEOUT_W{1'b0}};
      value_r      <= 16'h0000;
      dp_r         <= 4'h0;
      bad_r        <= 4'h0;
      valid_r      <= 1'b0;
      frame_tick_r <= 1'b0;
      stale_r      <= 1'b0;
    end else begin
      tmo_r        <= tmo_nxt_s;
      frame_tick_r <= publish_s;
      if (publish_s) begin
        value_r <= stg_value_r;
        dp_r    <= stg_dp_r;
        bad_r   <= stg_bad_r;
        valid_r <= 1'b1;
        stale_r <= 1'b0;
      end else if (tmo_nxt_s == TMO_MAX) begin
        valid_r <= 1'b0;
        stale_r <= 1'b1;
      end
    end
  end

  assign bus.value      = value_r;
  assign bus.dp         = dp_r;
  assign bus.bad_digit  = bad_r;
  assign bus.valid      = valid_r;
  assign bus.frame_tick = frame_tick_r;
  assign bus.stale      = stale_r;
endmodule

// File: tb/tb_sseg_to_bin_monitor.sv
// Directed bench for sseg_to_bin_monitor: expected frames are queued as scans are driven
// and compared when frame_tick fires.
module tb_sseg_to_bin_monitor;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  sseg_to_bin_monitor_if bus();

  sseg_to_bin_monitor #(.STABLE_CYC(16), .TIMEOUT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  bad;
  } frame_t;

  frame_t exp_q[$];
  int total   = 0;
  int bad_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every frame_tick must match the oldest queued frame.
  always @(negedge clk) begin
    frame_t f;
    if (bus.frame_tick === 1'b1) begin
      check("tick_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        check("frame_value", 32'(bus.value), 32'(f.value));
        check("frame_dp", 32'(bus.dp), 32'(f.dp));
        check("frame_bad", 32'(bus.bad_digit), 32'(f.bad));
        check("frame_valid", 32'(bus.valid), 32'd1);
      end
    end
  end

  task automatic show(input logic [3:0] an, input logic [7:0] sseg, input int n, input int clr_at);
    bus.an   = an;
    bus.sseg = sseg;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      bus.clr = (j == clr_at);
    end
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                      input logic [7:0] s3, input int len2, input int clr_at3);
    show(4'b1110, s0, 20, 0);
    show(4'b1101, s1, 20, 0);
    show(4'b1011, s2, len2, 0);
    show(4'b0111, s3, 20, clr_at3);
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    frame_t f;
    f.value = v;
    f.dp    = d;
    f.bad   = b;
    exp_q.push_back(f);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_value"}, 32'(bus.value), 32'd0);
    check({tag, "_dp"}, 32'(bus.dp), 32'd0);
    check({tag, "_bad"}, 32'(bus.bad_digit), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_stale"}, 32'(bus.stale), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.an   = 4'hF;
    bus.sseg = 8'hFF;
    bus.clr  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_tick", 32'(bus.frame_tick), 32'd0);
    reset_n = 1'b1;

    // Plain scan 2,3,4,5 with dp off.
    expect_frame(16'h5432, 4'h0, 4'h0);
    scan(8'hA4, 8'hB0, 8'h99, 8'h92, 20, 0);
    show(4'hF, 8'hFF, 5, 0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_valid_level", 32'(bus.valid), 32'd1);
    check("t1_stale", 32'(bus.stale), 32'd0);

    // Digit 2 too short: no frame, then timeout.
    scan(8'hA4, 8'hB0, 8'h99, 8'h92, 10, 0);
    scan(8'hA4, 8'hB0, 8'h99, 8'h92, 10, 0);
    show(4'hF, 8'hFF, 1, 0);
    for (int i = 0; i < 400 && bus.stale !== 1'b1; i++) @(negedge clk);
    check("t2_stale", 32'(bus.stale), 32'd1);
    check("t2_valid", 32'(bus.valid), 32'd0);
    check("t2_value_hold", 32'(bus.value), 32'h5432);

    // clr drops the partial mask and zeroes the outputs.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check_outputs_zero("clr");

    // Blank digit 1 with its dp lit.
    expect_frame(16'h5402, 4'b0010, 4'b0010);
    scan(8'hA4, 8'h7F, 8'h99, 8'h92, 20, 0);
    show(4'hF, 8'hFF, 5, 0);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Two enables low must not capture.
    show(4'b0011, 8'hC0, 40, 0);
    expect_frame(16'hADCF, 4'b1001, 4'h0);
    scan(8'h0E, 8'hC6, 8'hA1, 8'h08, 20, 0);
    show(4'hF, 8'hFF, 5, 0);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // clr on the fourth digit's capture cycle, then a normal scan.
    scan(8'hA4, 8'hB0, 8'h99, 8'h92, 20, 18);
    check_outputs_zero("t5_clr");
    expect_frame(16'h7610, 4'h0, 4'h0);
    scan(8'hC0, 8'hF9, 8'h82, 8'hF8, 20, 0);
    show(4'hF, 8'hFF, 5, 0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_valid", 32'(bus.valid), 32'd1);

    // Asynchronous reset in the middle of SETTLE.
    show(4'b1110, 8'h00, 8, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_frame(16'hEB98, 4'b1001, 4'h0);
    scan(8'h00, 8'h90, 8'h83, 8'h06, 20, 0);
    show(4'hF, 8'hFF, 5, 0);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end
endmodule
